// File: rtl/prefill_fifo_stream_reader.sv
// Read-domain consumer for the pre-filled async FIFO: waits for pre-fill, pops the FWFT port
// into a 2-entry skid buffer and emits fixed-length framed bursts, counting mid-frame starvation.
module prefill_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  pre_fill_done_sync,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic [1:0]            state
);

  localparam int PC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PC_W-1:0] LAST_IDX = PC_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FILL = 2'd1,
    S_STREAM    = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      count_q, count_d;
  logic [1:0][DATA_WIDTH-1:0]      data_q, data_d;
  logic [1:0]                      last_q, last_d;
  logic [PC_W-1:0]                 pop_cnt_q, pop_cnt_d;
  logic [UNDERRUN_W-1:0]           ur_q, ur_d;

  logic       accept;
  logic       has_space;
  logic       pop_block;
  logic [1:0] base;

  always_comb begin
    accept     = (count_q != 2'd0) && m_ready;
    has_space  = (count_q < 2'd2) || ((count_q == 2'd2) && accept);
    pop_block  = !enable && (pop_cnt_q == '0);
    fifo_rd_en = (state_q == S_STREAM) && !fifo_empty && has_space && !pop_block;

    // Shift out the accepted head first, then land the popped word in the first free slot.
    data_d    = data_q;
    last_d    = last_q;
    pop_cnt_d = pop_cnt_q;
    base      = count_q - 2'(accept);
    if (accept) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
    end
    if (fifo_rd_en) begin
      data_d[base[0]] = fifo_rd_data;
      last_d[base[0]] = (pop_cnt_q == LAST_IDX);
      pop_cnt_d       = (pop_cnt_q == LAST_IDX) ? '0 : pop_cnt_q + PC_W'(1);
    end
    count_d = base + 2'(fifo_rd_en);

    ur_d = ur_q;
    if ((state_q == S_STREAM) && (pop_cnt_q != '0) && fifo_empty &&
        (count_q == 2'd0) && (ur_q != '1)) begin
      ur_d = ur_q + UNDERRUN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_FILL;
      S_WAIT_FILL: begin
        if (!enable)                 state_d = S_IDLE;
        else if (pre_fill_done_sync) state_d = S_STREAM;
      end
      S_STREAM:    if (pop_block) state_d = S_FINISH;
      S_FINISH:    if (count_d == 2'd0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q   <= S_IDLE;
      count_q   <= 2'd0;
      data_q    <= '0;
      last_q    <= '0;
      pop_cnt_q <= '0;
      ur_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      last_q    <= last_d;
      pop_cnt_q <= pop_cnt_d;
      ur_q      <= ur_d;
    end
  end

  assign m_valid      = (count_q != 2'd0);
  assign m_data       = data_q[0];
  assign m_last       = last_q[0];
  assign underrun_cnt = ur_q;
  assign state        = state_q;

endmodule

// File: tb/tb_prefill_fifo_stream_reader.sv
// Bench for prefill_fifo_stream_reader: directed table rows, an async-reset sequence and a
// randomized run, all checked cycle by cycle against a queue-based behavioural model.
module tb_prefill_fifo_stream_reader;

  localparam int DW   = 8;
  localparam int FL   = 4;
  localparam int UW   = 2;
  localparam int UMAX = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          rd_rst;
  logic          enable;
  logic          pre_fill_done_sync;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [UW-1:0] underrun_cnt;
  logic [1:0]    state;

  prefill_fifo_stream_reader #(
    .DATA_WIDTH(DW), .FRAME_LEN(FL), .UNDERRUN_W(UW)
  ) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .enable(enable),
    .pre_fill_done_sync(pre_fill_done_sync), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .underrun_cnt(underrun_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Environment FIFO contents and the log of words the stream actually delivered.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] acc_d[$];
  bit            acc_l[$];
  logic [DW-1:0] next_word = 8'h10;

  // Behavioural model: phase, buffered {last,data} words, words popped in frame, underruns.
  int      ms;
  bit [8:0] mb[$];
  int      mpc;
  int      mur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 8'd1;
    end
  endtask

  task automatic model_reset();
    ms = 0;
    mb.delete();
    mpc = 0;
    mur = 0;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    enable = 1'b0;
    pre_fill_done_sync = 1'b0;
    m_ready = 1'b0;
    fq.delete();
    acc_d.delete();
    acc_l.delete();
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_underrun", int'(underrun_cnt), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    rd_rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: present FIFO state, compare DUT to model, advance both.
  task automatic step();
    bit exp_pop, acc, inc;
    int sz, nxt;
    fifo_empty = (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
    #1;
    sz = mb.size();
    exp_pop = (ms == 2) && !fifo_empty && (sz < 2 || (sz == 2 && m_ready)) &&
              !(!enable && mpc == 0);
    chk("state", int'(state), ms);
    chk("m_valid", int'(m_valid), int'(sz != 0));
    if (sz != 0) begin
      chk("m_data", int'(m_data), int'(mb[0][7:0]));
      chk("m_last", int'(m_last), int'(mb[0][8]));
    end
    chk("underrun_cnt", int'(underrun_cnt), mur);
    chk("fifo_rd_en", int'(fifo_rd_en), int'(exp_pop));
    chk("pop_when_empty", int'(fifo_rd_en && fifo_empty), 0);
    if (m_valid && m_ready) begin
      acc_d.push_back(m_data);
      acc_l.push_back(m_last);
      $display("xfer data=0x%02h last=%0d t=%0t", m_data, m_last, $time);
    end
    acc = (sz != 0) && m_ready;
    inc = (ms == 2) && (mpc != 0) && fifo_empty && (sz == 0);
    nxt = ms;
    case (ms)
      0: if (enable) nxt = 1;
      1: if (!enable) nxt = 0; else if (pre_fill_done_sync) nxt = 2;
      2: if (!enable && mpc == 0) nxt = 3;
      default: if (sz - int'(acc) + int'(exp_pop) == 0) nxt = 0;
    endcase
    if (inc && mur < UMAX) mur++;
    if (acc) void'(mb.pop_front());
    if (exp_pop) begin
      mb.push_back({mpc == FL - 1, fq[0]});
      mpc = (mpc + 1) % FL;
    end
    ms = nxt;
    if (fifo_rd_en && fq.size() != 0) void'(fq.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit       pre;
    bit [3:0] rdy_pat;
    int       push_n;
    int       cycles;
    int       exp_state;
    int       exp_ur;
    int       exp_acc;
    int       exp_left;
  } row_t;

  row_t rows[13];

  initial begin
    rd_rst = 1'b1;
    enable = 1'b0;
    pre_fill_done_sync = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    model_reset();

    //          rst en pre rdy      push cyc st ur acc left
    rows[0]  = '{1, 0, 0, 4'b0000, 0,  0,  0, 0, 0,  0};
    rows[1]  = '{0, 1, 0, 4'b1111, 0,  10, 1, 0, 0,  0};
    rows[2]  = '{0, 1, 1, 4'b1111, 8,  12, 2, 0, 8,  0};
    rows[3]  = '{0, 1, 1, 4'b1001, 8,  24, 2, 0, 16, 0};
    rows[4]  = '{0, 1, 1, 4'b1111, 2,  2,  2, 0, 17, 0};
    rows[5]  = '{0, 1, 1, 4'b1111, 0,  4,  2, 3, 18, 0};
    rows[6]  = '{0, 1, 1, 4'b1111, 6,  10, 2, 3, 24, 0};
    rows[7]  = '{1, 0, 0, 4'b0000, 0,  0,  0, 0, 0,  0};
    rows[8]  = '{0, 1, 1, 4'b1111, 1,  4,  2, 0, 1,  0};
    rows[9]  = '{0, 1, 1, 4'b1111, 0,  6,  2, 3, 1,  0};
    rows[10] = '{1, 0, 0, 4'b0000, 0,  0,  0, 0, 0,  0};
    rows[11] = '{0, 1, 1, 4'b1111, 12, 3,  2, 0, 0,  11};
    rows[12] = '{0, 0, 1, 4'b1111, 0,  10, 0, 0, 4,  8};

    @(negedge clk);
    for (int r = 0; r < 13; r++) begin
      if (rows[r].rst) begin
        do_reset();
      end else begin
        enable = rows[r].en;
        pre_fill_done_sync = rows[r].pre;
        push(rows[r].push_n);
        for (int c = 0; c < rows[r].cycles; c++) begin
          m_ready = rows[r].rdy_pat[c % 4];
          step();
        end
      end
      chk($sformatf("row%0d_state", r), int'(state), rows[r].exp_state);
      chk($sformatf("row%0d_underrun", r), int'(underrun_cnt), rows[r].exp_ur);
      chk($sformatf("row%0d_accepted", r), acc_d.size(), rows[r].exp_acc);
      chk($sformatf("row%0d_fifo_left", r), fq.size(), rows[r].exp_left);
      if (r == 2) begin
        for (int i = 0; i < 8 && i < acc_d.size(); i++) begin
          chk($sformatf("first_frames_data%0d", i), int'(acc_d[i]), 16 + i);
          chk($sformatf("first_frames_last%0d", i), int'(acc_l[i]), int'(i % 4 == 3));
        end
      end
      if (r == 12) begin
        for (int i = 0; i < 4 && i < acc_l.size(); i++)
          chk($sformatf("drain_frame_last%0d", i), int'(acc_l[i]), int'(i == 3));
      end
    end

    // Asynchronous reset while a word is pending mid-frame with underruns recorded.
    do_reset();
    enable = 1'b1;
    pre_fill_done_sync = 1'b1;
    m_ready = 1'b1;
    push(1);
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 3; c++) step();
    m_ready = 1'b0;
    push(2);
    for (int c = 0; c < 2; c++) step();
    chk("pre_arst_m_valid", int'(m_valid), 1);
    chk("pre_arst_underrun", int'(underrun_cnt), 3);
    #2;
    rd_rst = 1'b1;
    #1;
    chk("arst_m_valid", int'(m_valid), 0);
    chk("arst_underrun", int'(underrun_cnt), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_rd_en", int'(fifo_rd_en), 0);
    do_reset();

    // Randomized traffic with bursty supply, back-pressure and enable toggling.
    enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6) push(1);
      if ($urandom_range(0, 59) == 0) enable = !enable;
      pre_fill_done_sync = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
